// File: rtl/serial_nibble_loader.sv
// Serial-to-parallel word assembler with a hold-until-accepted output stage,
// sticky overrun detection and a delivered-word counter.
module serial_nibble_loader #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sin,
  input  logic             sin_valid,
  input  logic             data_ready,
  input  logic             clear_err,
  output logic [WIDTH-1:0] data,
  output logic             data_valid,
  output logic             busy,
  output logic [4:0]       bit_count,
  output logic             overrun,
  output logic [7:0]       word_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shreg_next;
  logic             last_bit;
  logic             ovr_set;

  function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] base,
                                                input logic bit_in);
    if (MSB_FIRST)
      return {base[WIDTH-2:0], bit_in};
    else
      return {bit_in, base[WIDTH-1:1]};
  endfunction

  assign shreg_next = shift_in(shreg, sin);
  assign last_bit   = (bit_count == 5'(WIDTH - 1));
  // A bit offered while a completed word is still waiting has nowhere to go.
  assign ovr_set    = (state == HOLD) && sin_valid && !data_ready;

  assign data_valid = (state == HOLD);
  assign busy       = (state == SHIFT);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      shreg      <= '0;
      data       <= '0;
      bit_count  <= '0;
      word_count <= '0;
      overrun    <= 1'b0;
    end else begin
      // Set takes priority over clear when both happen in one cycle.
      if (ovr_set)
        overrun <= 1'b1;
      else if (clear_err)
        overrun <= 1'b0;

      unique case (state)
        IDLE: begin
          if (sin_valid) begin
            shreg     <= shift_in('0, sin);
            bit_count <= 5'd1;
            state     <= SHIFT;
          end
        end
        SHIFT: begin
          if (sin_valid) begin
            if (last_bit) begin
              data      <= shreg_next;
              shreg     <= '0;
              bit_count <= '0;
              state     <= HOLD;
            end else begin
              shreg     <= shreg_next;
              bit_count <= bit_count + 5'd1;
            end
          end
        end
        HOLD: begin
          if (data_ready) begin
            word_count <= word_count + 8'd1;
            if (sin_valid) begin
              // Same-cycle bit starts the next word so nothing is lost.
              shreg     <= shift_in('0, sin);
              bit_count <= 5'd1;
              state     <= SHIFT;
            end else begin
              shreg <= '0;
              state <= IDLE;
            end
          end
        end
        default: begin
          shreg     <= '0;
          bit_count <= '0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_nibble_loader.sv
// Directed bench for serial_nibble_loader: completed words are checked by a
// scoreboard monitor, control/status outputs by inline checks.
module tb_serial_nibble_loader;

  logic       clk = 1'b0;
  logic       reset, sin, sin_valid, data_ready, clear_err;
  logic [3:0] data, data_l;
  logic       data_valid, busy, overrun;
  logic       data_valid_l, busy_l, overrun_l;
  logic [4:0] bit_count, bit_count_l;
  logic [7:0] word_count, word_count_l;

  int vectors = 0;
  int miscompares = 0;
  logic [3:0] expq[$];
  logic       prev_dv = 1'b0;

  always #5 clk = ~clk;

  serial_nibble_loader #(.WIDTH(4), .MSB_FIRST(1'b1)) dut (
    .clk(clk), .reset(reset), .sin(sin), .sin_valid(sin_valid),
    .data_ready(data_ready), .clear_err(clear_err), .data(data),
    .data_valid(data_valid), .busy(busy), .bit_count(bit_count),
    .overrun(overrun), .word_count(word_count)
  );

  serial_nibble_loader #(.WIDTH(4), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .reset(reset), .sin(sin), .sin_valid(sin_valid),
    .data_ready(data_ready), .clear_err(clear_err), .data(data_l),
    .data_valid(data_valid_l), .busy(busy_l), .bit_count(bit_count_l),
    .overrun(overrun_l), .word_count(word_count_l)
  );

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every new word presented on data must match the queue head.
  always @(negedge clk) begin
    if (data_valid === 1'b1 && prev_dv !== 1'b1) begin
      vectors++;
      if (expq.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_word: got %0h, expected no word", data);
      end else begin
        logic [3:0] e;
        e = expq.pop_front();
        if (data !== e) begin
          miscompares++;
          $display("FAIL word_data: got %0h, expected %0h", data, e);
        end
      end
    end
    prev_dv <= data_valid;
  end

  task automatic drive(input logic r, input logic sv, input logic s,
                       input logic rdy, input logic clr);
    reset = r; sin_valid = sv; sin = s; data_ready = rdy; clear_err = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic feed_word(input logic [3:0] w, input logic rdy);
    for (int i = 3; i >= 0; i--) drive(1'b0, 1'b1, w[i], rdy, 1'b0);
  endtask

  initial begin
    logic [3:0] bits;
    logic [4:0] exp_bc [4];
    logic       exp_busy [4];
    exp_bc = '{5'd1, 5'd2, 5'd3, 5'd0};
    exp_busy = '{1'b1, 1'b1, 1'b1, 1'b0};

    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst_data", 16'(data), 16'h0);
    chk("rst_valid", 16'(data_valid), 16'h0);
    chk("rst_busy", 16'(busy), 16'h0);
    chk("rst_bitcnt", 16'(bit_count), 16'h0);
    chk("rst_wordcnt", 16'(word_count), 16'h0);
    chk("rst_overrun", 16'(overrun), 16'h0);

    // Word 1010 MSB-first, 0101 LSB-first; downstream not ready.
    bits = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) expq.push_back(4'b1010);
      drive(1'b0, 1'b1, bits[3-i], 1'b0, 1'b0);
      chk($sformatf("bitcnt_%0d", i), 16'(bit_count), 16'(exp_bc[i]));
      chk($sformatf("busy_%0d", i), 16'(busy), 16'(exp_busy[i]));
    end
    chk("valid_after_4", 16'(data_valid), 16'h1);
    chk("lsb_first_data", 16'(data_l), 16'h5);

    // Overrun while holding, then clear; then set-wins-over-clear.
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("ovr_set", 16'(overrun), 16'h1);
    chk("ovr_data_held", 16'(data), 16'hA);
    chk("ovr_still_hold", 16'(data_valid), 16'h1);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("ovr_clear", 16'(overrun), 16'h0);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    chk("ovr_set_wins", 16'(overrun), 16'h1);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("ovr_clear2", 16'(overrun), 16'h0);

    // Handshake with no new bit returns to idle; data keeps last value.
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("hs_wordcnt", 16'(word_count), 16'h1);
    chk("hs_idle_valid", 16'(data_valid), 16'h0);
    chk("hs_idle_busy", 16'(busy), 16'h0);
    chk("hs_data_kept", 16'(data), 16'hA);

    // Back-to-back: handshake and first bit of next word on the same edge.
    expq.push_back(4'b1100);
    feed_word(4'b1100, 1'b1);
    chk("ready_ignored_in_shift", 16'(word_count), 16'h1);
    drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("b2b_wordcnt", 16'(word_count), 16'h2);
    chk("b2b_busy", 16'(busy), 16'h1);
    chk("b2b_bitcnt", 16'(bit_count), 16'h1);
    expq.push_back(4'b1111);
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("b2b_valid", 16'(data_valid), 16'h1);
    chk("b2b_no_overrun", 16'(overrun), 16'h0);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("b2b_wordcnt2", 16'(word_count), 16'h3);

    // Reset mid-word discards the partial word.
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("mid_bitcnt", 16'(bit_count), 16'h2);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("mid_rst_bitcnt", 16'(bit_count), 16'h0);
    chk("mid_rst_busy", 16'(busy), 16'h0);
    chk("mid_rst_data", 16'(data), 16'h0);
    chk("mid_rst_wordcnt", 16'(word_count), 16'h0);
    expq.push_back(4'b0110);
    feed_word(4'b0110, 1'b0);
    chk("after_rst_valid", 16'(data_valid), 16'h1);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("after_rst_wordcnt", 16'(word_count), 16'h1);

    // Wrap: 255 more words; the 256th handshake returns the count to 0.
    for (int n = 1; n < 255; n++) begin
      expq.push_back(4'(n));
      feed_word(4'(n), 1'b0);
      drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    end
    chk("wrap_255", 16'(word_count), 16'hFF);
    expq.push_back(4'b1001);
    feed_word(4'b1001, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("wrap_0", 16'(word_count), 16'h0);

    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("scoreboard_drained", 16'(expq.size()), 16'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/serial_nibble_loader.md
SERIAL_NIBBLE_LOADER -- requirements
Module: serial_nibble_loader

Interface
REQ-001 Parameter WIDTH, default 4, sets the assembled word width; the legal range SHALL be 2..16.
REQ-002 Parameter MSB_FIRST, default 1: 1 means the first serial bit lands in data[WIDTH-1]; 0 means the first serial bit lands in data[0].
REQ-003 Port clk, input, 1 bit: the single clock; all state SHALL update on the rising edge.
REQ-004 Port reset, input, 1 bit: synchronous, active-high reset, sampled on the clk rising edge.
REQ-005 Port sin, input, 1 bit: serial data bit.
REQ-006 Port sin_valid, input, 1 bit: sin is offered this cycle.
REQ-007 Port data_ready, input, 1 bit: the downstream register accepts data this cycle.
REQ-008 Port clear_err, input, 1 bit: clears the sticky overrun flag.
REQ-009 Port data, output, WIDTH bits: the assembled parallel word, which feeds the downstream flip-flop register's data input.
REQ-010 Port data_valid, output, 1 bit: data holds a complete word.
REQ-011 Port busy, output, 1 bit: a partial word is in assembly.
REQ-012 Port bit_count, output, 5 bits: the number of bits held in the partial word.
REQ-013 Port overrun, output, 1 bit: sticky flag indicating a serial bit was dropped.
REQ-014 Port word_count, output, 8 bits: the number of words delivered.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE (0 bits), SHIFT (1..WIDTH-1 bits), and HOLD (full word presented).
REQ-016 In IDLE, sin_valid=1 SHALL shift sin in, set bit_count to 1, and move to SHIFT.
REQ-017 In IDLE and SHIFT, sin_valid=0 SHALL hold all state; there is no timeout.
REQ-018 In SHIFT, sin_valid=1 SHALL shift sin in, and bit_count SHALL increment by 1.
REQ-019 When the accepted bit is the WIDTH-th bit, the shift register SHALL copy to data, bit_count SHALL go to 0, and the FSM SHALL move to HOLD.
REQ-020 Latency: if the WIDTH-th bit is accepted at edge N, data_valid SHALL be 1 and data SHALL be valid immediately after edge N (registered); there are no combinational paths from sin to data.
REQ-021 data_valid SHALL equal (state==HOLD), and busy SHALL equal (state==SHIFT).
REQ-022 data SHALL remain stable throughout HOLD, and SHALL also hold its last value in IDLE and SHIFT.
REQ-023 A handshake occurs in HOLD when data_ready=1; on that edge word_count SHALL increment modulo 256, wrapping from 255 to 0.
REQ-024 A handshake with sin_valid=0 SHALL move the FSM to IDLE.
REQ-025 A handshake with sin_valid=1 in the same cycle SHALL accept sin as bit 1 of the next word, set bit_count to 1, and move the FSM to SHIFT; no bit SHALL be lost.
REQ-026 In HOLD with data_ready=0 and sin_valid=1, the bit SHALL be dropped, overrun SHALL set to 1, and data and state SHALL be unchanged.
REQ-027 data_ready SHALL be ignored outside HOLD.
REQ-028 overrun SHALL stay set until clear_err=1 or reset.
REQ-029 If clear_err=1 and a new overrun event occur in the same cycle, set SHALL win and overrun SHALL remain 1.
REQ-030 The bit ordering for MSB_FIRST=1 SHALL be: shift left, with sin entering bit 0; after WIDTH bits, the first bit is the MSB.
REQ-031 The bit ordering for MSB_FIRST=0 SHALL be: shift right, with sin entering bit WIDTH-1; after WIDTH bits, the first bit is the LSB.
REQ-032 The shift register SHALL clear to 0 on entry to IDLE and at the start of each new word, so that no stale bits leak into data.

Reset
REQ-033 When reset=1 at a rising edge, the FSM SHALL go to IDLE, data, bit_count, word_count and the shift register SHALL be 0, and data_valid, busy and overrun SHALL be 0.
REQ-034 Reset SHALL take priority over every other input, including during SHIFT and HOLD; a partial or held word SHALL be discarded, and word_count SHALL not increment.
REQ-035 Outputs SHALL be undefined before the first reset edge; the bench SHALL apply reset for at least 2 cycles.

Verification
REQ-036 WIDTH=4, MSB_FIRST=1: serial bits 1,0,1,0 on consecutive cycles, with data_ready=0 -> data=4'b1010 and data_valid=1 after the 4th edge; busy=1 on cycles 1-3; bit_count sequence 1,2,3,0.
REQ-037 MSB_FIRST=0: the same bits 1,0,1,0 -> data=4'b0101.
REQ-038 Back-to-back: word 4'b1100 in HOLD, with data_ready=1 and sin_valid=1 (sin=1) on the same edge -> word_count increments to 1, state goes to SHIFT, bit_count=1; next word 1,1,1,1 -> data=4'b1111 with no overrun.
REQ-039 Overrun: in HOLD, with data_ready=0 and sin_valid=1 for 2 cycles -> overrun=1 and data unchanged; then clear_err=1 -> overrun=0 on the next edge.
REQ-040 Reset mid-word: after 2 bits are accepted, reset=1 for one edge -> bit_count=0, busy=0, data=0; the following 4 bits 0,1,1,0 -> data=4'b0110.
REQ-041 Wrap: deliver 256 words with data_ready=1 -> word_count reads 0, and the 255 to 0 transition occurs on the 256th handshake.
